// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader.
// Optional feature macro: IMEM_LOAD_CHECKSUM_EN (adds the trailing XOR checksum byte and CHECK state).
package imem_pkg;

    localparam int unsigned IMEM_DEPTH = 64;
    localparam int unsigned IMEM_AW    = 6;
    localparam int unsigned IMEM_DW    = 32;

`ifdef IMEM_LOAD_CHECKSUM_EN
    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StWrite,
        StCheck,
        StDone,
        StError
    } loader_state_e;
`else
    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StWrite,
        StDone,
        StError
    } loader_state_e;
`endif

    // A load length is legal when it is non-zero and fits in the memory.
    function automatic logic len_ok(input logic [6:0] n, input int unsigned depth);
        return (n != 7'd0) && ({25'd0, n} <= depth);
    endfunction

endpackage

// File: rtl/imem_word_asm.sv
// Byte-to-word assembler: big-endian shift register plus 2-bit byte counter.
// The first byte of a word ends up in the most significant byte lane.
module imem_word_asm
    import imem_pkg::*;
#(
    parameter int unsigned N = IMEM_DW
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         shift,
    input  logic [7:0]   din,
    output logic [N-1:0] word,
    output logic         last
);

    // Only the bytes already received are stored; the current byte completes the word.
    logic [N-9:0] part_q;
    logic [1:0]   cnt_q;

    assign word = {part_q, din};
    assign last = (cnt_q == 2'(N / 8 - 1));

    // Shift in one byte per accepted transfer; counter wraps after a full word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            part_q <= '0;
            cnt_q  <= '0;
        end else if (clear) begin
            part_q <= '0;
            cnt_q  <= '0;
        end else if (shift) begin
            part_q <= word[N-9:0];
            cnt_q  <= last ? 2'd0 : cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a byte stream, writes whole words to
// consecutive addresses, then releases the processor hold (cpu_rst_n).
// Optional feature macro: IMEM_LOAD_CHECKSUM_EN (one trailing XOR checksum byte).
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned N     = IMEM_DW,
    parameter int unsigned DEPTH = IMEM_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [6:0]         num_words,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               we,
    output logic [IMEM_AW-1:0] waddr,
    output logic [N-1:0]       wdata,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               cpu_rst_n
);

    loader_state_e state_q, state_d;
    logic [6:0]    word_cnt_q, word_cnt_d;
    logic [6:0]    num_q, num_d;
    logic          xfer;
    logic          shift;
    logic          asm_clear;
    logic          asm_last;
    logic [N-1:0]  asm_word;

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    // in_ready is registered from the state, so it already encodes RECV/CHECK.
    assign xfer  = in_valid && in_ready;
    assign shift = xfer && (state_q == StRecv);

    imem_word_asm #(
        .N (N)
    ) u_asm (
        .clk   (clk),
        .reset (reset),
        .clear (asm_clear),
        .shift (shift),
        .din   (in_data),
        .word  (asm_word),
        .last  (asm_last)
    );

    // Next-state and counter logic.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        num_d      = num_q;
        asm_clear  = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    if (len_ok(num_words, DEPTH)) begin
                        state_d    = StRecv;
                        word_cnt_d = '0;
                        num_d      = num_words;
                        asm_clear  = 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
                        csum_d     = '0;
`endif
                    end else begin
                        state_d = StError;
                    end
                end
            end
            StRecv: begin
                if (shift) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                    csum_d = csum_q ^ in_data;
`endif
                    if (asm_last) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                word_cnt_d = word_cnt_q + 7'd1;
                if (word_cnt_d == num_q) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                    state_d = StCheck;
`else
                    state_d = StDone;
`endif
                end else begin
                    state_d = StRecv;
                end
            end
`ifdef IMEM_LOAD_CHECKSUM_EN
            StCheck: begin
                if (xfer) begin
                    state_d = (in_data == csum_q) ? StDone : StError;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // State, counters and registered outputs (outputs follow the state being entered).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            word_cnt_q <= '0;
            num_q      <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum_q     <= '0;
`endif
            in_ready   <= 1'b0;
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cpu_rst_n  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            num_q      <= num_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum_q     <= csum_d;
            in_ready   <= (state_d == StRecv) || (state_d == StCheck);
            busy       <= (state_d == StRecv) || (state_d == StWrite) || (state_d == StCheck);
`else
            in_ready   <= (state_d == StRecv);
            busy       <= (state_d == StRecv) || (state_d == StWrite);
`endif
            we         <= (state_d == StWrite);
            done       <= (state_d == StDone);
            err        <= (state_d == StError);
            cpu_rst_n  <= (state_d == StDone);
            // Capture the completed word together with its index on entry to WRITE.
            if (shift && asm_last) begin
                waddr <= word_cnt_q[IMEM_AW-1:0];
                wdata <= asm_word;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte streams with gaps and
// ignored start pulses, checked against a transaction-level write model.
module tb_imem_loader;

    typedef logic [7:0] byte_q_t[$];

    logic        clk;
    logic        reset;
    logic        start;
    logic [6:0]  num_words;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        we;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_rst_n;

    int n_total = 0;
    int n_pass  = 0;

    // Expected writes, in order; the compare process walks them with rd_idx.
    logic [5:0]  exp_addr[$];
    logic [31:0] exp_data[$];
    int          rd_idx = 0;
    int          load_id = 0;
    int          seen_id[64];

    imem_loader #(
        .N     (32),
        .DEPTH (64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_words (num_words),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_rst_n (cpu_rst_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected $finish)");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Model: word w of a load is bytes 4w..4w+3, first byte most significant, at address w.
    task automatic model_writes(input byte_q_t bs, input int n);
        for (int w = 0; w < n; w++) begin
            exp_addr.push_back(6'(w));
            exp_data.push_back({bs[4*w], bs[4*w+1], bs[4*w+2], bs[4*w+3]});
        end
    endtask

    function automatic logic [7:0] xor_all(input byte_q_t bs);
        logic [7:0] x = 8'h00;
        foreach (bs[i]) x ^= bs[i];
        return x;
    endfunction

    task automatic do_start(input logic [6:0] n);
        @(posedge clk);
        #1;
        start     = 1'b1;
        num_words = n;
        @(posedge clk);
        #1;
        start     = 1'b0;
        num_words = 7'($urandom);
    endtask

    // Offer bytes with random valid gaps; optional start pulses that must be ignored.
    task automatic send_bytes(input byte_q_t bs, input int gap, input bit noise);
        foreach (bs[i]) begin
            bit hs;
            int budget;
            hs     = 1'b0;
            budget = 0;
            while (!hs) begin
                in_valid  = ($urandom_range(99) >= gap);
                in_data   = in_valid ? bs[i] : 8'($urandom);
                start     = noise && ($urandom_range(15) == 0);
                num_words = 7'd0;
                @(negedge clk);
                hs = in_valid && in_ready;
                @(posedge clk);
                #1;
                budget++;
                if (!hs && budget > 200) begin
                    check("byte accepted within budget", 0, 1);
                    in_valid = 1'b0;
                    start    = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_status(input bit exp_done, input bit exp_err);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(done || err) && cyc < 50);
        check("final status reached", done || err, 1);
        check("done", done, exp_done);
        check("err", err, exp_err);
        check("cpu_rst_n", cpu_rst_n, exp_done);
        check("all writes seen", rd_idx, exp_addr.size());
    endtask

    // One complete load; use_model=0 means the caller queued literal expectations.
    task automatic run_load(input byte_q_t bs, input int n, input int gap, input bit noise,
                            input bit use_model, input bit bad_csum);
        byte_q_t cs;
        load_id++;
        if (use_model) model_writes(bs, n);
        do_start(7'(n));
        @(negedge clk);
        check("busy after start", busy, 1);
        check("err cleared by start", err, 0);
        check("done cleared by start", done, 0);
        check("cpu held during load", cpu_rst_n, 0);
        @(posedge clk);
        #1;
        send_bytes(bs, gap, noise);
`ifdef IMEM_LOAD_CHECKSUM_EN
        cs = {};
        cs.push_back(xor_all(bs) ^ (bad_csum ? 8'h01 : 8'h00));
        send_bytes(cs, gap, noise);
        wait_status(!bad_csum, bad_csum);
`else
        cs = {};
        wait_status(1'b1, 1'b0);
`endif
    endtask

    // Compare process: every sampled cycle checks status coherence and each write.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (reset) begin
                check("status exclusive", $countones({busy, done, err}) <= 1, 1);
                check("cpu_rst_n follows done", cpu_rst_n, done);
                if (we) begin
                    check("in_ready low in write", in_ready, 0);
                    if (rd_idx >= exp_addr.size()) begin
                        check("unexpected write", 1, 0);
                    end else begin
                        check("waddr", waddr, exp_addr[rd_idx]);
                        check("wdata", wdata, exp_data[rd_idx]);
                        check("address written once", seen_id[waddr] == load_id, 0);
                        seen_id[waddr] = load_id;
                        rd_idx++;
                    end
                end
            end
        end
    end

    initial begin : main
        byte_q_t bs;
        foreach (seen_id[i]) seen_id[i] = 0;
        reset     = 1'b0;
        start     = 1'b0;
        num_words = 7'd0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        #1;
        check("reset in_ready", in_ready, 0);
        check("reset we", we, 0);
        check("reset waddr", waddr, 0);
        check("reset wdata", wdata, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset err", err, 0);
        check("reset cpu_rst_n", cpu_rst_n, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Three-word load with literal expected words.
        bs = {8'hF8, 8'h00, 8'h00, 8'h00, 8'hF8, 8'h00, 8'h80, 8'h01,
              8'hCB, 8'h0E, 8'h01, 8'hCE};
        exp_addr.push_back(6'd0); exp_data.push_back(32'hF8000000);
        exp_addr.push_back(6'd1); exp_data.push_back(32'hF8008001);
        exp_addr.push_back(6'd2); exp_data.push_back(32'hCB0E01CE);
        run_load(bs, 3, 30, 1'b0, 1'b0, 1'b0);

`ifdef IMEM_LOAD_CHECKSUM_EN
        // Checksum 08 matches 12^34^56^78; 09 must be rejected.
        bs = {8'h12, 8'h34, 8'h56, 8'h78};
        exp_addr.push_back(6'd0); exp_data.push_back(32'h12345678);
        run_load(bs, 1, 0, 1'b0, 1'b0, 1'b0);
        exp_addr.push_back(6'd0); exp_data.push_back(32'h12345678);
        run_load(bs, 1, 0, 1'b0, 1'b0, 1'b1);
`else
        // No trailing byte is consumed once the last word is written.
        bs = {8'h12, 8'h34, 8'h56, 8'h78};
        exp_addr.push_back(6'd0); exp_data.push_back(32'h12345678);
        run_load(bs, 1, 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (4) begin
            @(negedge clk);
            check("no trailing byte accepted", in_ready, 0);
            check("done holds", done, 1);
        end
        in_valid = 1'b0;
`endif

        // Illegal lengths: error on the next cycle, no writes, processor held.
        do_start(7'd0);
        @(negedge clk);
        check("len 0 err", err, 1);
        check("len 0 done", done, 0);
        check("len 0 cpu_rst_n", cpu_rst_n, 0);
        do_start(7'd65);
        @(negedge clk);
        check("len 65 err", err, 1);
        check("len 65 busy", busy, 0);
        check("len 65 cpu_rst_n", cpu_rst_n, 0);
        repeat (3) @(negedge clk);
        check("error holds", err, 1);

        // Full depth with valid gaps and ignored start pulses.
        bs = {};
        for (int i = 0; i < 256; i++) bs.push_back(8'($urandom));
        run_load(bs, 64, 40, 1'b1, 1'b1, 1'b0);

        // Assorted random loads.
        for (int r = 0; r < 6; r++) begin
            int n;
            n  = $urandom_range(1, 8);
            bs = {};
            for (int i = 0; i < 4 * n; i++) bs.push_back(8'($urandom));
            run_load(bs, n, $urandom_range(0, 60), 1'b1, 1'b1, 1'b0);
        end

        // Mid-load reset after 5 bytes of a 2-word load.
        bs = {};
        for (int i = 0; i < 8; i++) bs.push_back(8'($urandom));
        load_id++;
        model_writes(bs, 1);
        do_start(7'd2);
        send_bytes(bs[0:4], 20, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("mid reset in_ready", in_ready, 0);
        check("mid reset we", we, 0);
        check("mid reset waddr", waddr, 0);
        check("mid reset wdata", wdata, 0);
        check("mid reset busy", busy, 0);
        check("mid reset done", done, 0);
        check("mid reset err", err, 0);
        check("mid reset cpu_rst_n", cpu_rst_n, 0);
        check("first word written before reset", rd_idx, exp_addr.size());
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        bs = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        exp_addr.push_back(6'd0); exp_data.push_back(32'hAABBCCDD);
        run_load(bs, 1, 20, 1'b0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter N, default 32, the instruction word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, the instruction memory depth in words; the address width is 6.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle load request.
REQ-006 SHALL have port num_words  input  7  number of words to load, sampled on start.
REQ-007 SHALL have port in_data  input  8  stream byte.
REQ-008 SHALL have port in_valid  input  1  in_data is valid.
REQ-009 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port we  output  1  instruction memory write strobe.
REQ-011 SHALL have port waddr  output  6  instruction memory write address.
REQ-012 SHALL have port wdata  output  N  instruction memory write data.
REQ-013 SHALL have ports busy, done, err  output  1 each  loader status.
REQ-014 SHALL have port cpu_rst_n  output  1  active-low processor hold; it is low until a load completes successfully.

Function
REQ-015 SHALL implement the FSM states IDLE, RECV, WRITE, CHECK, DONE and ERROR.
REQ-016 In IDLE, start with num_words in 1..64 SHALL clear the word counter, byte counter and checksum, and SHALL enter RECV the next cycle.
REQ-017 In IDLE, start with num_words equal to 0 or greater than 64 SHALL enter ERROR with no writes.
REQ-018 A byte transfer SHALL occur only when in_valid and in_ready are both 1; in_ready SHALL be 1 only in RECV and in CHECK.
REQ-019 Bytes SHALL assemble big-endian: the first byte of a word goes to bits 31:24 and the fourth byte to bits 7:0.
REQ-020 The transfer of the fourth byte SHALL move the FSM to WRITE.
REQ-021 WRITE SHALL last exactly one cycle, with we=1, waddr equal to the word index (0-based) and wdata equal to the assembled word.
REQ-022 we SHALL be 0 in every other state.
REQ-023 After WRITE, the FSM SHALL return to RECV if words remain.
REQ-024 After the last WRITE, the FSM SHALL go to CHECK if IMEM_LOAD_CHECKSUM_EN is defined, and to DONE otherwise.
REQ-025 The write address SHALL be unique per word: a 64-word load writes addresses 0..63, with no wrap and no rewrite.
REQ-026 DONE SHALL assert done=1 and cpu_rst_n=1 and hold them until reset or until a new start.
REQ-027 A start while in DONE or ERROR SHALL clear done and err, drive cpu_rst_n=0, and begin a new load under the rules of REQ-016 and REQ-017.
REQ-028 A start while in RECV, WRITE or CHECK SHALL be ignored.
REQ-029 busy SHALL be 1 in RECV, WRITE and CHECK.
REQ-030 err SHALL be 1 only in ERROR.
REQ-031 cpu_rst_n SHALL be 0 in every state except DONE.
REQ-032 in_valid held 0 SHALL stall the FSM indefinitely; there is no timeout.

Reset
REQ-033 Assertion of reset SHALL force, at any time including mid-load, the following: state=IDLE, counters=0, checksum=0, in_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, err=0, cpu_rst_n=0.
REQ-034 Memory contents already written before a reset SHALL be left untouched.

Configuration
REQ-035 With IMEM_LOAD_CHECKSUM_EN defined:
- the loader SHALL keep a running XOR of all payload bytes;
- after the last word it SHALL accept exactly one checksum byte in CHECK;
- on a match it SHALL go to DONE;
- on a mismatch it SHALL go to ERROR, with cpu_rst_n held 0.
REQ-036 Without IMEM_LOAD_CHECKSUM_EN, no checksum logic and no CHECK state SHALL exist, and no trailing byte SHALL be consumed.

Structure
REQ-037 A shared package imem_pkg SHALL hold the loader state enum, IMEM_DEPTH=64, IMEM_AW=6 and the word width constant.
REQ-038 The byte-to-word assembler (shift register plus 2-bit byte counter) SHALL be one sub-module, imem_word_asm.

Verification
REQ-039 Load test: start, num_words=3, bytes F8 00 00 00 F8 00 80 01 CB 0E 01 CE -> three we pulses writing addr0=F8000000, addr1=F8008001, addr2=CB0E01CE, then done=1 and cpu_rst_n=1.
REQ-040 Length error test: start with num_words=0, and separately with num_words=65 -> err=1 the next cycle, we never 1, cpu_rst_n=0.
REQ-041 Full-depth and stall test: num_words=64 with random in_valid gaps -> 64 writes to addresses 0..63 in order, no write to any address twice, and in_ready=0 during every WRITE cycle.
REQ-042 Checksum test (macro defined): bytes 12 34 56 78 followed by 08 -> done; the same bytes followed by 09 -> err=1, done=0.
REQ-043 Mid-load reset test: assert reset after 5 bytes, release, start again with num_words=1 -> the first write goes to addr0 with data assembled only from the new bytes.
